imem_sync: RTL and testbench

Parametrised, synchronous successor to the combinational instruction memory feeding the fetch stage of the 8-bit pipelined processor. It provides a registered read with a valid/stall handshake toward IF/ID, and a write port for loading programs at run time instead of fixed contents. A self-timed clear engine fills the whole array with NOP, and out-of-range fetches are flagged.

---
 rtl/imem_sync_if.sv | 36 +++
 rtl/imem_sync.sv | 160 ++++++++++++++++
 tb/tb_imem_sync.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_sync_if.sv
// rtl/imem_sync_if.sv - fetch, program-load and clear signal bundle for imem_sync
//
// Groups every non-clock/reset signal of the instruction memory.
//   master : driven by the fetch stage / loader (requests, writes, clear pulse)
//   slave  : driven by imem_sync (fetched word, valid, error, busy)
// Signals:
//   rd_req, rd_addr, rd_stall   fetch request, PC, hazard-unit stall
//   rd_valid, rd_instr, rd_err  registered fetch result
//   wr_en, wr_addr, wr_data     program-load write port
//   clr_start, busy             clear engine start pulse and status
interface imem_sync_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
);
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_stall;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_instr;
   logic              rd_err;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              clr_start;
   logic              busy;

   modport master (
      output rd_req, rd_addr, rd_stall, wr_en, wr_addr, wr_data, clr_start,
      input  rd_valid, rd_instr, rd_err, busy
   );

   modport slave (
      input  rd_req, rd_addr, rd_stall, wr_en, wr_addr, wr_data, clr_start,
      output rd_valid, rd_instr, rd_err, busy
   );
endinterface

// File: rtl/imem_sync.sv
// rtl/imem_sync.sv - synchronous instruction memory with fetch handshake, load port and clear engine
//
// Registered-read instruction memory for the fetch stage. One-cycle read
// latency into an output register that the hazard unit can freeze with
// rd_stall. Programs are loaded through the write port; a self-timed clear
// engine fills the whole array with NOP_WORD in exactly DEPTH cycles.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset (array contents not reset)
//   bus    slave modport of imem_sync_if:
//          rd_req/rd_addr/rd_stall in, rd_valid/rd_instr/rd_err out,
//          wr_en/wr_addr/wr_data in, clr_start in, busy out
//
// Build option:
//   IMEM_BYPASS_EN  when defined, a same-cycle write and fetch to the same
//                   in-range address returns the new word (write-first);
//                   when undefined the fetch returns the old word
//                   (read-first) and no compare logic is built.
module imem_sync #(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 8,
   parameter int                DEPTH    = 256,
   parameter logic [DATA_W-1:0] NOP_WORD = 16'h0000
) (
   input logic        clk,
   input logic        rst_n,
   imem_sync_if.slave bus
);

   // A one-entry memory still needs a 1-bit counter.
   localparam int                CNT_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // One extra bit so DEPTH == 2**ADDR_W is representable in the range check.
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEPTH - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              busy_q;

   logic              rd_valid_q;
   logic [DATA_W-1:0] rd_instr_q;
   logic              rd_err_q;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              rd_in_range;
   logic              wr_in_range;
   logic              wr_fire;
   logic              clr_fire;
   logic [CNT_W-1:0]  rd_idx;
   logic [CNT_W-1:0]  wr_idx;
   logic [DATA_W-1:0] rd_word;

   assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_EXT);
   assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_EXT);
   assign rd_idx      = bus.rd_addr[CNT_W-1:0];
   assign wr_idx      = bus.wr_addr[CNT_W-1:0];

   // The load port is locked out for the whole clear; busy_q is high exactly
   // while the FSM is in CLEAR, so the two array writers never collide.
   assign wr_fire  = bus.wr_en && wr_in_range && !busy_q;
   assign clr_fire = (state == ST_CLEAR);

   // Array write port. No reset: contents survive rst_n, and a reset in the
   // middle of a clear drops state to IDLE asynchronously, so no further
   // entries are cleared after it.
   always_ff @(posedge clk) begin
      if (clr_fire) begin
         mem[cnt] <= NOP_WORD;
      end else if (wr_fire) begin
         mem[wr_idx] <= bus.wr_data;
      end
   end

   // Word presented to the output register. For out-of-range addresses the
   // truncated index may point anywhere; that value is discarded below.
   always_comb begin
      rd_word = mem[rd_idx];
`ifdef IMEM_BYPASS_EN
      if (wr_fire && (bus.wr_addr == bus.rd_addr)) begin
         rd_word = bus.wr_data;
      end
`endif
   end

   // Clear engine. clr_start is only looked at in IDLE, so a pulse during a
   // clear cannot restart it. A write in the same cycle as clr_start still
   // lands (busy_q is low) and is overwritten once the sweep reaches it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         busy_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.clr_start) begin
                  state  <= ST_CLEAR;
                  cnt    <= '0;
                  busy_q <= 1'b1;
               end
            end
            ST_CLEAR: begin
               // The last entry is written on the same edge that leaves CLEAR,
               // giving exactly DEPTH busy cycles with no counter wrap.
               if (cnt == CNT_LAST) begin
                  state  <= ST_IDLE;
                  cnt    <= '0;
                  busy_q <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state  <= ST_IDLE;
               cnt    <= '0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   // Output register. Stall freezes everything and wins over both a request
   // and an ongoing clear; the PC must be held upstream while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_q <= 1'b0;
         rd_instr_q <= NOP_WORD;
         rd_err_q   <= 1'b0;
      end else if (bus.rd_stall) begin
         rd_valid_q <= rd_valid_q;
         rd_instr_q <= rd_instr_q;
         rd_err_q   <= rd_err_q;
      end else if (busy_q || !bus.rd_req) begin
         // rd_instr keeps the last fetched word; only the flags drop.
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
      end else if (rd_in_range) begin
         rd_valid_q <= 1'b1;
         rd_instr_q <= rd_word;
         rd_err_q   <= 1'b0;
      end else begin
         rd_valid_q <= 1'b1;
         rd_instr_q <= NOP_WORD;
         rd_err_q   <= 1'b1;
      end
   end

   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_instr = rd_instr_q;
   assign bus.rd_err   = rd_err_q;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_imem_sync.sv
// tb/tb_imem_sync.sv - scoreboard testbench for imem_sync
module tb_imem_sync;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 200;

   typedef struct {
      logic [DATA_W+1:0] resp;   // {rd_valid, rd_err, rd_instr}
      string             name;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];
   logic [DATA_W-1:0] model [2**ADDR_W];

   always #5 clk = ~clk;

   imem_sync_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   imem_sync #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .DEPTH   (DEPTH),
      .NOP_WORD(16'h0000)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.rd_req    = 1'b0;
      bus.rd_addr   = '0;
      bus.rd_stall  = 1'b0;
      bus.wr_en     = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_data   = '0;
      bus.clr_start = 1'b0;
   endtask

   task automatic write_word(input logic [7:0] a, input logic [15:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      tick();
      bus.wr_en = 1'b0;
      if (int'(a) < DEPTH) model[a] = d;
   endtask

   task automatic push_exp(input logic v, input logic e, input logic [15:0] ins, input string nm);
      exp_t x;
      x.resp = {v, e, ins};
      x.name = nm;
      exp_q.push_back(x);
   endtask

   task automatic test_reset();
      idle_inputs();
      #3;
      checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.rd_valid); end
      checks++; if (bus.rd_instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h expected 0000", bus.rd_instr); end
      checks++; if (bus.rd_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.rd_err); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_back_to_back();
      exp_t x;
      logic [17:0] act;
      write_word(8'h00, 16'h1044);
      write_word(8'h01, 16'h1081);
      for (int i = 0; i < 3; i++) begin
         bus.rd_req  = (i < 2);
         bus.rd_addr = 8'(i);
         if (i == 0)      push_exp(1'b1, 1'b0, 16'h1044, "b2b_addr0");
         else if (i == 1) push_exp(1'b1, 1'b0, 16'h1081, "b2b_addr1");
         else             push_exp(1'b0, 1'b0, 16'h1081, "b2b_idle_hold");
         tick();
         x = exp_q.pop_front();
         act = {bus.rd_valid, bus.rd_err, bus.rd_instr};
         checks++;
         if (act !== x.resp) begin errors++; $display("FAIL %s: got %h expected %h", x.name, act, x.resp); end
      end
      idle_inputs();
   endtask

   task automatic test_stall();
      exp_t x;
      logic [17:0] act;
      logic       req_t   [7] = '{1, 1, 1, 1, 1, 0, 0};
      logic [7:0] addr_t  [7] = '{8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02};
      logic       stall_t [7] = '{0, 1, 1, 1, 0, 1, 0};
      logic       v_t     [7] = '{1, 1, 1, 1, 1, 1, 0};
      logic [15:0] ins_t  [7] = '{16'h1081, 16'h1081, 16'h1081, 16'h1081, 16'h2b3c, 16'h2b3c, 16'h2b3c};
      write_word(8'h02, 16'h2b3c);
      for (int i = 0; i < 7; i++) begin
         bus.rd_req   = req_t[i];
         bus.rd_addr  = addr_t[i];
         bus.rd_stall = stall_t[i];
         push_exp(v_t[i], 1'b0, ins_t[i], $sformatf("stall_step%0d", i));
         tick();
         x = exp_q.pop_front();
         act = {bus.rd_valid, bus.rd_err, bus.rd_instr};
         checks++;
         if (act !== x.resp) begin errors++; $display("FAIL %s: got %h expected %h", x.name, act, x.resp); end
      end
      idle_inputs();
   endtask

   task automatic test_out_of_range();
      exp_t x;
      logic [17:0] act;
      logic [7:0]  addr_t  [5] = '{8'hC8, 8'hFF, 8'hC7, 8'hC7, 8'hC7};
      logic        req_t   [5] = '{1, 1, 1, 1, 0};
      logic        stall_t [5] = '{0, 0, 1, 0, 0};
      logic        v_t     [5] = '{1, 1, 1, 1, 0};
      logic        e_t     [5] = '{1, 1, 1, 0, 0};
      logic [15:0] ins_t   [5] = '{16'h0000, 16'h0000, 16'h0000, 16'h5a5a, 16'h5a5a};
      write_word(8'hC7, 16'h5a5a);
      write_word(8'hC8, 16'hBEEF);
      for (int i = 0; i < 5; i++) begin
         bus.rd_req   = req_t[i];
         bus.rd_addr  = addr_t[i];
         bus.rd_stall = stall_t[i];
         push_exp(v_t[i], e_t[i], ins_t[i], $sformatf("oor_step%0d", i));
         tick();
         x = exp_q.pop_front();
         act = {bus.rd_valid, bus.rd_err, bus.rd_instr};
         checks++;
         if (act !== x.resp) begin errors++; $display("FAIL %s: got %h expected %h", x.name, act, x.resp); end
      end
      idle_inputs();
   endtask

   task automatic test_clear();
      exp_t x;
      logic [17:0] act;
      int busy_cycles;
      logic [7:0] addr_t [3] = '{8'h05, 8'h00, 8'(DEPTH - 1)};
      write_word(8'h05, 16'h0daa);
      write_word(8'(DEPTH - 1), 16'h7777);
      bus.clr_start = 1'b1;
      tick();
      bus.clr_start = 1'b0;
      bus.rd_req    = 1'b1;
      bus.rd_addr   = 8'h05;
      busy_cycles   = 0;
      while (bus.busy === 1'b1 && busy_cycles < 4 * DEPTH) begin
         busy_cycles++;
         // A restart pulse and a load write mid-clear must both be ignored.
         bus.clr_start = (busy_cycles == 50);
         bus.wr_en     = (busy_cycles == 60);
         bus.wr_addr   = 8'h00;
         bus.wr_data   = 16'h1234;
         tick();
         checks++;
         if ({bus.rd_valid, bus.rd_err} !== 2'b00) begin
            errors++;
            $display("FAIL clear_read_blocked: cycle %0d got valid/err %b%b expected 00", busy_cycles, bus.rd_valid, bus.rd_err);
         end
      end
      checks++;
      if (busy_cycles != DEPTH) begin errors++; $display("FAIL clear_length: got %0d busy cycles expected %0d", busy_cycles, DEPTH); end
      idle_inputs();
      for (int k = 0; k < DEPTH; k++) model[k] = 16'h0000;
      for (int i = 0; i < 3; i++) begin
         bus.rd_req  = 1'b1;
         bus.rd_addr = addr_t[i];
         push_exp(1'b1, 1'b0, model[addr_t[i]], $sformatf("after_clear_addr%0h", addr_t[i]));
         tick();
         x = exp_q.pop_front();
         act = {bus.rd_valid, bus.rd_err, bus.rd_instr};
         checks++;
         if (act !== x.resp) begin errors++; $display("FAIL %s: got %h expected %h", x.name, act, x.resp); end
      end
      idle_inputs();
   endtask

   task automatic test_reset_during_clear();
      exp_t x;
      logic [17:0] act;
      for (int k = 0; k < 11; k++) write_word(8'(k), 16'h0100 + 16'(k));
      write_word(8'd20, 16'h058a);
      bus.clr_start = 1'b1;
      tick();
      bus.clr_start = 1'b0;
      repeat (10) tick();
      rst_n = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_clear_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_clear_valid: got %b expected 0", bus.rd_valid); end
      tick();
      rst_n = 1'b1;
      tick();
      for (int k = 0; k < 10; k++) model[k] = 16'h0000;
      for (int k = 0; k < 12; k++) begin
         bus.rd_req  = 1'b1;
         bus.rd_addr = (k == 11) ? 8'd20 : 8'(k);
         push_exp(1'b1, 1'b0, model[bus.rd_addr], $sformatf("partial_clear_addr%0d", bus.rd_addr));
         tick();
         x = exp_q.pop_front();
         act = {bus.rd_valid, bus.rd_err, bus.rd_instr};
         checks++;
         if (act !== x.resp) begin errors++; $display("FAIL %s: got %h expected %h", x.name, act, x.resp); end
      end
      idle_inputs();
   endtask

   task automatic test_same_cycle();
      exp_t x;
      logic [17:0] act;
      write_word(8'h09, 16'h5280);
      for (int i = 0; i < 2; i++) begin
         bus.rd_req  = 1'b1;
         bus.rd_addr = 8'h09;
         bus.wr_en   = (i == 0);
         bus.wr_addr = 8'h09;
         bus.wr_data = 16'h072e;
         if (i == 0) begin
`ifdef IMEM_BYPASS_EN
            push_exp(1'b1, 1'b0, 16'h072e, "same_cycle_rw");
`else
            push_exp(1'b1, 1'b0, 16'h5280, "same_cycle_rw");
`endif
         end else begin
            push_exp(1'b1, 1'b0, 16'h072e, "after_same_cycle_rw");
         end
         tick();
         x = exp_q.pop_front();
         act = {bus.rd_valid, bus.rd_err, bus.rd_instr};
         checks++;
         if (act !== x.resp) begin errors++; $display("FAIL %s: got %h expected %h", x.name, act, x.resp); end
      end
      model[9] = 16'h072e;
      idle_inputs();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_back_to_back();
      test_stall();
      test_out_of_range();
      test_clear();
      test_reset_during_clear();
      test_same_cycle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
